// File: rtl/icache_pkg.sv
// Shared types and default widths for the icache miss controller and its MSHR file.
// The MSHR entry layout is sized from the DEF_* constants, so top-level widths must match them.
package icache_pkg;

  localparam int DEF_PADDR_W   = 32;
  localparam int DEF_XLEN      = 64;
  localparam int DEF_OFF_W     = 3;
  localparam int DEF_IDX_W     = 2;
  localparam int DEF_NUM_MSHR  = 4;
  localparam int DEF_MEM_TAG_W = 4;
  localparam int DEF_LINE_W    = DEF_PADDR_W - DEF_OFF_W;
  localparam int DEF_TAG_W     = DEF_LINE_W - DEF_IDX_W;

  typedef enum logic [1:0] {
    BUS_NONE = 2'h0,
    BUS_LOAD = 2'h1
  } bus_cmd_e;

  typedef struct packed {
    logic                     valid;
    logic [DEF_LINE_W-1:0]    line;
    logic [DEF_MEM_TAG_W-1:0] mem_tag;
  } mshr_entry_t;

endpackage

// File: rtl/icache_mshr_ctrl_if.sv
// Fetch / array / memory-bus signal bundle of the icache miss controller.
// slave = controller side, master = environment (fetch, array, memory) side.
interface icache_mshr_ctrl_if
  import icache_pkg::*;
#(
  parameter int XLEN      = DEF_XLEN,
  parameter int MEM_TAG_W = DEF_MEM_TAG_W,
  parameter int IDX_W     = DEF_IDX_W,
  parameter int TAG_W     = DEF_TAG_W
);
  logic                 proc2Icache_req;
  logic [XLEN-1:0]      proc2Icache_addr;
  logic                 cachemem_hit;
  logic [XLEN-1:0]      cachemem_data;
  logic [MEM_TAG_W-1:0] Imem2proc_response;
  logic [XLEN-1:0]      Imem2proc_data;
  logic [MEM_TAG_W-1:0] Imem2proc_tag;
  logic [XLEN-1:0]      Icache_data_out;
  logic                 Icache_valid_out;
  logic [1:0]           proc2Imem_command;
  logic [XLEN-1:0]      proc2Imem_addr;
  logic                 wr_en;
  logic [IDX_W-1:0]     wr_index;
  logic [TAG_W-1:0]     wr_tag;
  logic [XLEN-1:0]      wr_data;
  logic                 mshr_full;

  modport slave (
    input  proc2Icache_req, proc2Icache_addr, cachemem_hit, cachemem_data,
           Imem2proc_response, Imem2proc_data, Imem2proc_tag,
    output Icache_data_out, Icache_valid_out, proc2Imem_command, proc2Imem_addr,
           wr_en, wr_index, wr_tag, wr_data, mshr_full
  );

  modport master (
    output proc2Icache_req, proc2Icache_addr, cachemem_hit, cachemem_data,
           Imem2proc_response, Imem2proc_data, Imem2proc_tag,
    input  Icache_data_out, Icache_valid_out, proc2Imem_command, proc2Imem_addr,
           wr_en, wr_index, wr_tag, wr_data, mshr_full
  );
endinterface

// File: rtl/icache_mshr_ctrl_mshr_file.sv
// MSHR array: line/tag CAM lookups, lowest-free allocation and free count.
// ICACHE_PREFETCH_EN adds a second line lookup port for the prefetch candidate.
module mshr_file
  import icache_pkg::*;
#(
  parameter int NUM_MSHR = DEF_NUM_MSHR,
  parameter int CNT_W    = $clog2(NUM_MSHR + 1)
) (
  input  logic                     clk_sys,
  input  logic                     rst_b,
  input  logic [DEF_LINE_W-1:0]    lookup_line_i,
  output logic                     line_hit_o,
`ifdef ICACHE_PREFETCH_EN
  input  logic [DEF_LINE_W-1:0]    pf_line_i,
  output logic                     pf_hit_o,
`endif
  input  logic [DEF_MEM_TAG_W-1:0] fill_tag_i,
  output logic                     fill_hit_o,
  output logic [DEF_LINE_W-1:0]    fill_line_o,
  input  logic                     alloc_en_i,
  input  logic [DEF_LINE_W-1:0]    alloc_line_i,
  input  logic [DEF_MEM_TAG_W-1:0] alloc_tag_i,
  output logic [CNT_W-1:0]         free_cnt_o
);

  mshr_entry_t ent_q [NUM_MSHR];
  mshr_entry_t ent_d [NUM_MSHR];
  int          fill_idx;
  int          alloc_idx;
  logic        have_free;
  logic        dup_tag;

  always_comb begin
    line_hit_o  = 1'b0;
    fill_hit_o  = 1'b0;
    fill_line_o = '0;
    fill_idx    = 0;
    alloc_idx   = 0;
    have_free   = 1'b0;
    dup_tag     = 1'b0;
    free_cnt_o  = '0;
`ifdef ICACHE_PREFETCH_EN
    pf_hit_o    = 1'b0;
`endif
    for (int i = 0; i < NUM_MSHR; i++) begin
      if (ent_q[i].valid) begin
        if (ent_q[i].line == lookup_line_i) line_hit_o = 1'b1;
`ifdef ICACHE_PREFETCH_EN
        if (ent_q[i].line == pf_line_i) pf_hit_o = 1'b1;
`endif
        if ((fill_tag_i != '0) && (ent_q[i].mem_tag == fill_tag_i)) begin
          fill_hit_o  = 1'b1;
          fill_idx    = i;
          fill_line_o = ent_q[i].line;
        end
        // a tag returning this cycle may legally be reused by the new request
        if ((ent_q[i].mem_tag == alloc_tag_i) && (alloc_tag_i != fill_tag_i)) dup_tag = 1'b1;
      end else begin
        free_cnt_o = free_cnt_o + CNT_W'(1);
        if (!have_free) begin
          have_free = 1'b1;
          alloc_idx = i;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_MSHR; i++) ent_d[i] = ent_q[i];
    if (fill_hit_o) ent_d[fill_idx].valid = 1'b0;
    if (alloc_en_i && have_free) begin
      ent_d[alloc_idx].valid   = 1'b1;
      ent_d[alloc_idx].line    = alloc_line_i;
      ent_d[alloc_idx].mem_tag = alloc_tag_i;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      for (int i = 0; i < NUM_MSHR; i++) ent_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_MSHR; i++) ent_q[i] <= ent_d[i];
    end
  end

  a_no_dup_tag: assert property (@(posedge clk_sys) disable iff (!rst_b)
    !(alloc_en_i && have_free && dup_tag));

endmodule

// File: rtl/icache_mshr_ctrl.sv
// Instruction-cache miss controller with up to NUM_MSHR outstanding fills, miss merging and fill forwarding.
// ICACHE_PREFETCH_EN enables a one-entry next-line prefetcher sharing the MSHRs.
module icache_mshr_ctrl
  import icache_pkg::*;
#(
  parameter int PADDR_W   = DEF_PADDR_W,
  parameter int XLEN      = DEF_XLEN,
  parameter int OFF_W     = DEF_OFF_W,
  parameter int IDX_W     = DEF_IDX_W,
  parameter int NUM_MSHR  = DEF_NUM_MSHR,
  parameter int MEM_TAG_W = DEF_MEM_TAG_W
) (
  input logic               clock,
  input logic               reset,
  icache_mshr_ctrl_if.slave bus
);

  localparam int LINE_W = PADDR_W - OFF_W;
  localparam int CNT_W  = $clog2(NUM_MSHR + 1);

  logic [LINE_W-1:0] fetch_line;
  logic [LINE_W-1:0] fill_line;
  logic [LINE_W-1:0] alloc_line;
  logic [CNT_W-1:0]  free_cnt;
  logic              line_hit;
  logic              fill_hit;
  logic              fill_fwd;
  logic              demand_req;
  logic              alloc_en;
  bus_cmd_e          cmd;
  logic              unused_addr_lo;

  assign fetch_line     = bus.proc2Icache_addr[PADDR_W-1:OFF_W];
  assign unused_addr_lo = ^bus.proc2Icache_addr[OFF_W-1:0];

`ifdef ICACHE_PREFETCH_EN
  logic              pf_valid_q, pf_valid_d;
  logic [LINE_W-1:0] pf_line_q, pf_line_d;
  logic              pf_hit;
  logic [XLEN-1:0]   pf_addr;
`endif

  mshr_file #(.NUM_MSHR(NUM_MSHR)) u_mshr (
    .clk_sys      (clock),
    .rst_b        (reset),
    .lookup_line_i(fetch_line),
    .line_hit_o   (line_hit),
`ifdef ICACHE_PREFETCH_EN
    .pf_line_i    (pf_line_q),
    .pf_hit_o     (pf_hit),
`endif
    .fill_tag_i   (bus.Imem2proc_tag),
    .fill_hit_o   (fill_hit),
    .fill_line_o  (fill_line),
    .alloc_en_i   (alloc_en),
    .alloc_line_i (alloc_line),
    .alloc_tag_i  (bus.Imem2proc_response),
    .free_cnt_o   (free_cnt)
  );

  always_comb begin
    fill_fwd   = fill_hit && (fill_line == fetch_line);
    // an entry freed by this cycle's fill only counts as free from the next edge
    demand_req = bus.proc2Icache_req && !bus.cachemem_hit && !line_hit && !fill_fwd
                 && (free_cnt != '0);
    cmd        = BUS_NONE;
    alloc_en   = 1'b0;
    alloc_line = fetch_line;
    bus.proc2Imem_addr = {bus.proc2Icache_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
`ifdef ICACHE_PREFETCH_EN
    pf_valid_d = pf_valid_q;
    pf_line_d  = pf_line_q;
    pf_addr    = '0;
    pf_addr[PADDR_W-1:OFF_W] = pf_line_q;
`endif
    if (demand_req) begin
      cmd      = BUS_LOAD;
      alloc_en = (bus.Imem2proc_response != '0);
`ifdef ICACHE_PREFETCH_EN
      if (alloc_en) begin
        pf_valid_d = 1'b1;
        pf_line_d  = fetch_line + LINE_W'(1);
      end
`endif
    end
`ifdef ICACHE_PREFETCH_EN
    else if (pf_valid_q) begin
      if (pf_hit) begin
        pf_valid_d = 1'b0;
      end else if (32'(free_cnt) >= 32'd2) begin
        cmd                = BUS_LOAD;
        bus.proc2Imem_addr = pf_addr;
        alloc_line         = pf_line_q;
        if (bus.Imem2proc_response != '0) begin
          alloc_en   = 1'b1;
          pf_valid_d = 1'b0;
        end
      end
    end
`endif

    bus.Icache_valid_out  = bus.proc2Icache_req && (bus.cachemem_hit || fill_fwd);
    bus.Icache_data_out   = fill_fwd ? bus.Imem2proc_data : bus.cachemem_data;
    bus.proc2Imem_command = cmd;
    if (!reset) begin
      bus.Icache_valid_out  = 1'b0;
      bus.proc2Imem_command = BUS_NONE;
    end
  end

  assign bus.wr_en     = fill_hit;
  assign bus.wr_index  = fill_line[IDX_W-1:0];
  assign bus.wr_tag    = fill_line[LINE_W-1:IDX_W];
  assign bus.wr_data   = bus.Imem2proc_data;
  assign bus.mshr_full = (free_cnt == '0);

`ifdef ICACHE_PREFETCH_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pf_valid_q <= 1'b0;
      pf_line_q  <= '0;
    end else begin
      pf_valid_q <= pf_valid_d;
      pf_line_q  <= pf_line_d;
    end
  end
`endif

endmodule

// File: tb/tb_icache_mshr_ctrl.sv
// Directed bench for icache_mshr_ctrl: allocation, merging, retry, full, fill/forward, reset, prefetch.
module tb_icache_mshr_ctrl;
  import icache_pkg::*;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;

  always #5 clock = ~clock;

  icache_mshr_ctrl_if bus ();

  icache_mshr_ctrl dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // apply one cycle of stimulus and let the combinational outputs settle
  task automatic drive(input logic req, input logic [63:0] addr, input logic hit,
                       input logic [63:0] cdata, input logic [3:0] resp,
                       input logic [3:0] mtag, input logic [63:0] mdata);
    bus.proc2Icache_req    = req;
    bus.proc2Icache_addr   = addr;
    bus.cachemem_hit       = hit;
    bus.cachemem_data      = cdata;
    bus.Imem2proc_response = resp;
    bus.Imem2proc_tag      = mtag;
    bus.Imem2proc_data     = mdata;
    #1;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    reset = 1'b0;
    cyc();
    reset = 1'b1;
  endtask

  function automatic int count_valid();
    int n = 0;
    for (int i = 0; i < DEF_NUM_MSHR; i++) if (dut.u_mshr.ent_q[i].valid) n++;
    return n;
  endfunction

  initial begin
    drive(1, 64'h100, 1, 64'h1, 0, 0, 0);
    chk("rst_valid_out", bus.Icache_valid_out, 0);
    chk("rst_cmd", bus.proc2Imem_command, BUS_NONE);
    chk("rst_full", bus.mshr_full, 0);
    chk("rst_wr_en", bus.wr_en, 0);
    cyc();
    cyc();
    reset = 1'b1;

`ifndef ICACHE_PREFETCH_EN
    // first miss allocates MSHR0
    cyc(); drive(1, 64'h100, 0, 0, 3, 0, 0);
    chk("miss_cmd", bus.proc2Imem_command, BUS_LOAD);
    chk("miss_addr", bus.proc2Imem_addr, 64'h100);
    chk("miss_full", bus.mshr_full, 0);
    cyc(); drive(1, 64'h100, 0, 0, 0, 0, 0);
    chk("mshr0_valid", dut.u_mshr.ent_q[0].valid, 1);
    chk("mshr0_tag", dut.u_mshr.ent_q[0].mem_tag, 3);
    chk("merge_cmd", bus.proc2Imem_command, BUS_NONE);

    // fill all MSHRs, then full
    do_reset();
    for (int i = 0; i < 4; i++) begin
      cyc(); drive(1, 64'h100 + 64'(8 * i), 0, 0, 4'(i + 1), 0, 0);
      chk("fill_up_cmd", bus.proc2Imem_command, BUS_LOAD);
      chk("fill_up_addr", bus.proc2Imem_addr, 64'h100 + 64'(8 * i));
    end
    cyc(); drive(1, 64'h120, 0, 0, 0, 0, 0);
    chk("full_flag", bus.mshr_full, 1);
    chk("full_cmd", bus.proc2Imem_command, BUS_NONE);
    cyc(); drive(1, 64'h120, 0, 0, 0, 2, 64'h55);
    chk("full_fill_wr_en", bus.wr_en, 1);
    chk("full_fill_index", bus.wr_index, 1);
    chk("full_fill_tag", bus.wr_tag, 8);
    chk("full_fill_data", bus.wr_data, 64'h55);
    chk("full_fill_cmd", bus.proc2Imem_command, BUS_NONE);
    chk("full_fill_valid", bus.Icache_valid_out, 0);
    cyc(); drive(1, 64'h120, 0, 0, 5, 0, 0);
    chk("after_free_cmd", bus.proc2Imem_command, BUS_LOAD);
    chk("after_free_addr", bus.proc2Imem_addr, 64'h120);
    chk("after_free_full", bus.mshr_full, 0);
    // second miss to in-flight line 0x110 merges; one fill serves it
    cyc(); drive(1, 64'h110, 0, 0, 0, 0, 0);
    chk("refull_flag", bus.mshr_full, 1);
    chk("inflight_cmd", bus.proc2Imem_command, BUS_NONE);
    cyc(); drive(1, 64'h110, 0, 0, 0, 3, 64'h1234);
    chk("merge_fwd_valid", bus.Icache_valid_out, 1);
    chk("merge_fwd_data", bus.Icache_data_out, 64'h1234);
    chk("merge_fwd_wr_en", bus.wr_en, 1);
    chk("merge_fwd_index", bus.wr_index, 2);
    chk("merge_fwd_cmd", bus.proc2Imem_command, BUS_NONE);

    // rejected requests repeat until accepted
    do_reset();
    for (int k = 0; k < 3; k++) begin
      cyc(); drive(1, 64'h200, 0, 0, 0, 0, 0);
      chk("retry_cmd", bus.proc2Imem_command, BUS_LOAD);
      chk("retry_addr", bus.proc2Imem_addr, 64'h200);
    end
    cyc(); drive(1, 64'h200, 0, 0, 5, 0, 0);
    chk("retry_accept_cmd", bus.proc2Imem_command, BUS_LOAD);
    cyc(); drive(1, 64'h200, 0, 0, 0, 0, 0);
    chk("retry_one_mshr", count_valid(), 1);
    chk("retry_merge_cmd", bus.proc2Imem_command, BUS_NONE);

    // forward on fill matching fetch line at a non-zero offset
    cyc(); drive(1, 64'h300, 0, 0, 6, 0, 0);
    chk("fwd_miss_addr", bus.proc2Imem_addr, 64'h300);
    cyc(); drive(1, 64'h304, 0, 64'h1111, 0, 6, 64'hDEAD);
    chk("fwd_valid", bus.Icache_valid_out, 1);
    chk("fwd_data", bus.Icache_data_out, 64'hDEAD);
    chk("fwd_wr_en", bus.wr_en, 1);
    chk("fwd_index", bus.wr_index, 0);
    chk("fwd_tag", bus.wr_tag, 64'h18);

    // hit while a stale MSHR fills the array
    cyc(); drive(1, 64'h500, 1, 64'hBEEF, 0, 5, 64'h77);
    chk("hit_valid", bus.Icache_valid_out, 1);
    chk("hit_data", bus.Icache_data_out, 64'hBEEF);
    chk("stale_wr_en", bus.wr_en, 1);
    chk("stale_tag", bus.wr_tag, 64'h10);
    chk("hit_cmd", bus.proc2Imem_command, BUS_NONE);
    cyc(); drive(0, 64'h500, 0, 0, 0, 9, 64'h77);
    chk("unknown_tag_wr_en", bus.wr_en, 0);
    chk("idle_valid", bus.Icache_valid_out, 0);
`else
    // prefetch of next line on the first idle cycle
    do_reset();
    cyc(); drive(1, 64'h400, 0, 0, 1, 0, 0);
    chk("pf_demand_cmd", bus.proc2Imem_command, BUS_LOAD);
    chk("pf_demand_addr", bus.proc2Imem_addr, 64'h400);
    cyc(); drive(0, 0, 0, 0, 2, 0, 0);
    chk("pf_cmd", bus.proc2Imem_command, BUS_LOAD);
    chk("pf_addr", bus.proc2Imem_addr, 64'h408);
    cyc(); drive(0, 0, 0, 0, 0, 0, 0);
    chk("pf_done_cmd", bus.proc2Imem_command, BUS_NONE);
    chk("pf_two_mshr", count_valid(), 2);
    cyc(); drive(1, 64'h408, 0, 0, 0, 2, 64'hCAFE);
    chk("pf_fwd_valid", bus.Icache_valid_out, 1);
    chk("pf_fwd_data", bus.Icache_data_out, 64'hCAFE);
    chk("pf_fill_wr_en", bus.wr_en, 1);
`endif

    // reset with a fill outstanding: the late tag is ignored
    do_reset();
    cyc(); drive(1, 64'h600, 0, 0, 7, 0, 0);
    chk("pre_rst_cmd", bus.proc2Imem_command, BUS_LOAD);
    cyc(); drive(1, 64'h600, 1, 0, 0, 7, 64'h99);
    reset = 1'b0;
    #1;
    chk("midrst_wr_en", bus.wr_en, 0);
    chk("midrst_full", bus.mshr_full, 0);
    chk("midrst_valid", bus.Icache_valid_out, 0);
    chk("midrst_cmd", bus.proc2Imem_command, BUS_NONE);
    chk("midrst_mshrs", count_valid(), 0);
    cyc();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 7, 64'h99);
    chk("late_tag_wr_en", bus.wr_en, 0);

    cyc();
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/icache_mshr_ctrl.md
# icache_mshr_ctrl

Parametrised instruction-cache miss controller sitting between the fetch stage, the icache data/tag array and the memory bus. It generalises the single-miss icache controller to up to `NUM_MSHR` outstanding line fills, each tracked by its memory transaction tag. It merges duplicate misses, forwards returning data directly to fetch, and drives the array write port. An optional next-line prefetcher shares the same miss-status holding registers (MSHRs).

## Interface
- `PADDR_W`, 32: physical address bits used; must be at most `XLEN`.
- `XLEN`, 64: address and data width.
- `OFF_W`, 3: line offset bits (8-byte lines).
- `IDX_W`, 2: cache index bits. `TAG_W` is derived as `PADDR_W-OFF_W-IDX_W`.
- `NUM_MSHR`, 4: maximum outstanding fills, range 1..15.
- `MEM_TAG_W`, 4: memory transaction tag width.

Ports:
- `clock`  in  1  clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `proc2Icache_req`  in  1  fetch request valid.
- `proc2Icache_addr`  in  XLEN  fetch address.
- `cachemem_hit`  in  1  array hit for the current address (combinational from the array).
- `cachemem_data`  in  XLEN  array data.
- `Imem2proc_response`  in  MEM_TAG_W  tag accepted this cycle; 0 means rejected.
- `Imem2proc_data`  in  XLEN  returned line data.
- `Imem2proc_tag`  in  MEM_TAG_W  tag of the returned data; 0 means none.
- `Icache_data_out`  out  XLEN  fetch data.
- `Icache_valid_out`  out  1  fetch data valid.
- `proc2Imem_command`  out  2  `BUS_LOAD` or `BUS_NONE`.
- `proc2Imem_addr`  out  XLEN  line-aligned request address.
- `wr_en`  out  1  array fill enable.
- `wr_index`  out  IDX_W  array fill index.
- `wr_tag`  out  TAG_W  array fill tag.
- `wr_data`  out  XLEN  array fill data.
- `mshr_full`  out  1  all MSHRs valid.

## Operation
- Each MSHR holds `valid`, `line` (`PADDR_W-OFF_W` bits) and `mem_tag`.
- Demand miss: `req && !cachemem_hit` and no valid MSHR holds the same line.
  - Drive `BUS_LOAD` with address `{addr[XLEN-1:OFF_W], 0}`.
- Miss to a line already held in an MSHR: no bus request; the miss is merged.
- Nonzero `Imem2proc_response` during `BUS_LOAD`: allocate the lowest-index free MSHR with that tag.
- Zero response: nothing is allocated; the request repeats next cycle while the miss persists.
- No free MSHR: `BUS_NONE`, and `mshr_full=1`.
- Fill: a nonzero `Imem2proc_tag` matching a valid MSHR causes, in the same cycle:
  - `wr_en=1`;
  - `wr_index` and `wr_tag` taken from that MSHR's line, `wr_data=Imem2proc_data`;
  - the MSHR is freed at the clock edge.
- Fill with no matching MSHR: ignored, `wr_en=0`.
- Fetch output: `Icache_valid_out = req && (cachemem_hit || fill forward)`.
  - Fill forward means the fill line equals the fetch line.
  - `Icache_data_out` is `Imem2proc_data` when forwarding, otherwise `cachemem_data`.
- Simultaneous fill and allocation:
  - the entry being freed is not reusable until the next cycle;
  - a fill for the current fetch line suppresses a new request for that line.
- Duplicate tags: a memory tag equal to a live MSHR tag is a protocol violation and is flagged by a simulation assertion.

## Timing
- Asynchronous reset: all MSHR and prefetch state is cleared immediately.
  - During and after reset, outputs are `BUS_NONE`, `wr_en=0`, `mshr_full=0`, `Icache_valid_out=0`.
  - Outstanding bus transactions are forgotten; their late fills are ignored.
- Hit: `Icache_valid_out` in the same cycle (zero-cycle latency).
- Miss: `BUS_LOAD` in the same cycle as the miss; the MSHR becomes valid at the next edge.
- Fill: `wr_en` and the forward occur combinationally in the cycle the tag returns.
- The address may change at any time; stale MSHRs still fill the array.
- At most one bus request per cycle; demand always wins over prefetch.

## Configuration
- `ICACHE_PREFETCH_EN` defined:
  - Each demand allocation loads a one-entry prefetch register with line+1, wrapping modulo `2^(PADDR_W-OFF_W)`.
  - The prefetch is issued on cycles with no demand request, and only when at least 2 MSHRs are free.
  - It is dropped if a valid MSHR already holds that line, or if a new demand allocation overwrites it.
  - A prefetch MSHR fills the array but is never forwarded unless it matches the current fetch line.
- Undefined: no prefetch register; behaviour is demand-only.

## Structure
- Shared package `icache_pkg`:
  - `BUS_LOAD` / `BUS_NONE` encodings;
  - `mshr_entry_t` struct;
  - derived-width helper constants.
- One sub-module, `mshr_file`, holds the entry array and provides:
  - line CAM lookup;
  - tag CAM lookup;
  - lowest-free priority allocation;
  - free count.

## Test plan
- Reset, then `req` to address `0x100` with `hit=0`, response `3` → `BUS_LOAD` to `0x100`; MSHR0 becomes valid with tag 3; `mshr_full=0`.
- Misses to lines `0x100`, `0x108`, `0x110`, `0x118`, each accepted, then a miss to `0x120` → `mshr_full=1`, `BUS_NONE`; tag `2` returns → `wr_en`, and `0x120` is requested next cycle.
- Miss on `0x200` with response `0` for 3 cycles, then `5` → `BUS_LOAD` held for 4 cycles and exactly one MSHR allocated.
- Outstanding fill for `0x300` with fetch at `0x304`, tag returns with data `0xDEAD` → same cycle `Icache_valid_out=1`, `Icache_data_out=0xDEAD`, `wr_en=1`.
- Second fetch miss to an in-flight line → no second `BUS_LOAD`; a single fill serves it.
- `ICACHE_PREFETCH_EN`: miss on `0x400` with free MSHRs → next idle cycle `BUS_LOAD 0x408`. Reset asserted mid-flight → a late tag produces `wr_en=0`.
